// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : types_pkg
// Description : Shared types and helpers for select_action_seq.
//               - opr_mode_t  : operation selector encodings
//               - seq_state_t : top-level sequencer states
//               - leading_ones_fn / count_ones_fn : bit counters that work
//                 for any word width up to MAX_W, given the live width.
// Revision    : 1.0 - initial registered/handshaked release
// ============================================================================
package types_pkg;

    // Widest word the counting helpers accept; callers zero-extend into it.
    localparam int MAX_W = 64;

    // Result width of the counting helpers (holds 0..MAX_W).
    typedef logic [6:0] cnt_t;

    typedef enum logic [2:0] {
        OP_RESET        = 3'd0,
        OP_ADD          = 3'd1,
        OP_SUB          = 3'd2,
        OP_MUL          = 3'd3,
        OP_LEADING_ONES = 3'd4,
        OP_COUNT_ONES   = 3'd5
    } opr_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DONE_ST = 2'd2
    } seq_state_t;

    // Consecutive 1s starting at bit (w-1) and walking toward bit 0.
    function automatic cnt_t leading_ones_fn(input logic [MAX_W-1:0] v, input int w);
        cnt_t cnt;
        logic run;
        cnt = '0;
        run = 1'b1;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                if (run && v[i]) begin
                    cnt = cnt + 7'd1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

    // Population count of the low w bits.
    function automatic cnt_t count_ones_fn(input logic [MAX_W-1:0] v, input int w);
        cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                cnt = cnt + {6'd0, v[i]};
            end
        end
        return cnt;
    endfunction

endpackage : types_pkg
`default_nettype wire

// File: rtl/select_action_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : select_action_seq_if
// Description : Request/result bundle between the switch/button front end
//               and the select_action_seq sequencer.
//               master : drives START/SELECTOR/SW, observes results
//               slave  : the sequencer (consumes request, drives results)
//               Signals: START, SELECTOR, SW[WIDTH], BUSY, DONE, LED[WIDTH], FLAG
// Revision    : 1.0 - initial release
// ============================================================================
interface select_action_seq_if
    import types_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             START;
    opr_mode_t        SELECTOR;
    logic [WIDTH-1:0] SW;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] LED;
    logic             FLAG;

    modport master (
        output START, SELECTOR, SW,
        input  BUSY, DONE, LED, FLAG
    );

    modport slave (
        input  START, SELECTOR, SW,
        output BUSY, DONE, LED, FLAG
    );

endinterface : select_action_seq_if
`default_nettype wire

// File: rtl/select_action_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative shift-add unsigned multiplier, one multiplier bit
//               per cycle (LSB first), HALF cycles per product.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   load_i    : capture a_i/b_i and start (ignored semantics left to caller)
//   a_i, b_i  : HALF-bit operands
//   busy_o    : iterations pending
//   done_o    : high during the final iteration cycle; product_o is final
//               and valid to sample on the closing edge of that cycle
//   product_o : 2*HALF-bit product (accumulator after the current step)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int HALF = 8
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              load_i,
    input  wire logic [HALF-1:0]   a_i,
    input  wire logic [HALF-1:0]   b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2*HALF-1:0]      product_o
);

    localparam int CW = $clog2(HALF + 1);

    logic [2*HALF-1:0] acc_q;
    logic [2*HALF-1:0] mcand_q;
    logic [HALF-1:0]   mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;

    logic [2*HALF-1:0] acc_d;

    // Accumulator value after the step in progress; on the last step this is
    // the finished product, which lets the caller latch it on the same edge.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{HALF{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= CW'(HALF);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CW'(1));
    assign product_o = acc_d;

endmodule : seq_multiplier
`default_nettype wire

// File: rtl/select_action_seq.sv
`default_nettype none
// ============================================================================
// Module      : select_action_seq
// Description : Registered, handshaked operation selector. Captures SW and
//               SELECTOR on START, produces a held LED result and FLAG,
//               pulses DONE for one cycle. MUL runs on seq_multiplier.
//   CLK100MHZ  : clock
//   CPU_RESETN : asynchronous active-low reset
//   bus        : slave side of select_action_seq_if
//                (START, SELECTOR, SW in; BUSY, DONE, LED, FLAG out)
// Revision    : 1.0 - initial release
// ============================================================================
module select_action_seq
    import types_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic           CLK100MHZ,
    input  wire logic           CPU_RESETN,
    select_action_seq_if.slave  bus
);

    localparam int HALF = WIDTH / 2;

    seq_state_t       state_q;
    logic [WIDTH-1:0] led_q;
    logic             flag_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] led_d;
    logic             flag_d;
    logic             accept;
    logic             mul_load;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [HALF-1:0]  op_a;
    logic [HALF-1:0]  op_b;
    logic [HALF:0]    add_sum;
    logic [WIDTH-1:0] sub_diff;
    cnt_t             lo_cnt;
    cnt_t             co_cnt;

    assign op_a = bus.SW[WIDTH-1:HALF];
    assign op_b = bus.SW[HALF-1:0];

    // DONE_ST accepts a new request exactly like IDLE (back-to-back).
    assign accept   = bus.START && (state_q != MUL_RUN);
    assign mul_load = accept && (bus.SELECTOR == OP_MUL);

    always_comb begin
        add_sum  = {1'b0, op_a} + {1'b0, op_b};
        sub_diff = {{HALF{1'b0}}, op_a} - {{HALF{1'b0}}, op_b};
        lo_cnt   = leading_ones_fn(MAX_W'(bus.SW), WIDTH);
        co_cnt   = count_ones_fn(MAX_W'(bus.SW), WIDTH);
        led_d    = '0;
        flag_d   = 1'b0;
        case (bus.SELECTOR)
            OP_ADD: begin
                led_d  = WIDTH'(add_sum);
                flag_d = add_sum[HALF];
            end
            OP_SUB: begin
                led_d  = sub_diff;
                flag_d = (op_a < op_b);
            end
            OP_LEADING_ONES: led_d = WIDTH'(lo_cnt);
            OP_COUNT_ONES:   led_d = WIDTH'(co_cnt);
            default: begin
                led_d  = '0;
                flag_d = 1'b0;
            end
        endcase
    end

    seq_multiplier #(
        .HALF (HALF)
    ) u_mul (
        .clk_i     (CLK100MHZ),
        .rst_ni    (CPU_RESETN),
        .load_i    (mul_load),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            led_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE_ST: begin
                    if (accept) begin
                        if (bus.SELECTOR == OP_MUL) begin
                            state_q <= MUL_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            // Single-cycle ops commit on the capture edge.
                            state_q <= DONE_ST;
                            led_q   <= led_d;
                            flag_q  <= flag_d;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    if (mul_busy && mul_done) begin
                        state_q <= DONE_ST;
                        led_q   <= mul_product;
                        flag_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.LED  = led_q;
    assign bus.FLAG = flag_q;

endmodule : select_action_seq
`default_nettype wire

// File: tb/tb_select_action_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_select_action_seq
// Description : Directed self-checking bench for select_action_seq, WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_select_action_seq;
    import types_pkg::*;

    localparam int WIDTH = 16;

    logic CLK100MHZ;
    logic CPU_RESETN;
    int   checks;
    int   errors;

    select_action_seq_if #(.WIDTH(WIDTH)) bus ();

    select_action_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .bus        (bus)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input opr_mode_t sel, input logic [WIDTH-1:0] sw);
        bus.START    = 1'b1;
        bus.SELECTOR = sel;
        bus.SW       = sw;
        tick();
        bus.START    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.START    = 1'b0;
        bus.SELECTOR = OP_RESET;
        bus.SW       = '0;
        CPU_RESETN   = 1'b0;
        #23;
        check("rst_led",  32'(bus.LED),  32'h0);
        check("rst_flag", 32'(bus.FLAG), 32'h0);
        check("rst_busy", 32'(bus.BUSY), 32'h0);
        check("rst_done", 32'(bus.DONE), 32'h0);
        CPU_RESETN = 1'b1;
        tick();

        // ADD FF+01
        issue(OP_ADD, 16'hFF01);
        check("add_done", 32'(bus.DONE), 32'h1);
        check("add_busy", 32'(bus.BUSY), 32'h0);
        check("add_led",  32'(bus.LED),  32'h0100);
        check("add_flag", 32'(bus.FLAG), 32'h1);
        tick();
        check("add_done_drop", 32'(bus.DONE), 32'h0);
        check("add_led_hold",  32'(bus.LED),  32'h0100);

        // RESET op clears result
        issue(OP_RESET, 16'h1234);
        check("rop_led",  32'(bus.LED),  32'h0);
        check("rop_flag", 32'(bus.FLAG), 32'h0);
        tick();

        // SUB with and without borrow
        issue(OP_SUB, 16'h0305);
        check("sub1_led",  32'(bus.LED),  32'hFFFE);
        check("sub1_flag", 32'(bus.FLAG), 32'h1);
        tick();
        issue(OP_SUB, 16'h0503);
        check("sub2_led",  32'(bus.LED),  32'h0002);
        check("sub2_flag", 32'(bus.FLAG), 32'h0);
        tick();

        // MUL FF*FF with noise while busy
        issue(OP_MUL, 16'hFFFF);
        check("mul_busy0", 32'(bus.BUSY), 32'h1);
        check("mul_done0", 32'(bus.DONE), 32'h0);
        for (int i = 1; i < 8; i++) begin
            bus.START    = 1'b1;
            bus.SELECTOR = (i % 2 == 0) ? OP_ADD : OP_COUNT_ONES;
            bus.SW       = 16'(i * 16'h0111);
            if (i == 7) bus.START = 1'b0;
            tick();
            check("mul_busy", 32'(bus.BUSY), 32'h1);
            check("mul_nodone", 32'(bus.DONE), 32'h0);
            check("mul_led_hold", 32'(bus.LED), 32'h0002);
        end
        bus.START = 1'b0;
        tick();
        check("mul_done", 32'(bus.DONE), 32'h1);
        check("mul_busy_end", 32'(bus.BUSY), 32'h0);
        check("mul_led",  32'(bus.LED),  32'hFE01);
        check("mul_flag", 32'(bus.FLAG), 32'h0);
        tick();
        check("mul_single_done", 32'(bus.DONE), 32'h0);
        check("mul_led_hold2",   32'(bus.LED),  32'hFE01);

        // Counting ops
        issue(OP_LEADING_ONES, 16'hF0FF);
        check("lo_f0ff", 32'(bus.LED), 32'd4);
        tick();
        issue(OP_COUNT_ONES, 16'hF0FF);
        check("co_f0ff", 32'(bus.LED), 32'd12);
        tick();
        issue(OP_LEADING_ONES, 16'hFFFF);
        check("lo_ffff", 32'(bus.LED), 32'd16);
        tick();
        issue(OP_COUNT_ONES, 16'h7FFF);
        check("co_7fff", 32'(bus.LED), 32'd15);
        tick();
        issue(OP_LEADING_ONES, 16'h7FFF);
        check("lo_7fff", 32'(bus.LED), 32'd0);
        tick();

        // Back-to-back: START held through the DONE cycle
        bus.START    = 1'b1;
        bus.SELECTOR = OP_COUNT_ONES;
        bus.SW       = 16'hFFFF;
        tick();
        check("b2b_first_done", 32'(bus.DONE), 32'h1);
        check("b2b_first_led",  32'(bus.LED),  32'd16);
        bus.SELECTOR = OP_ADD;
        bus.SW       = 16'h0102;
        tick();
        bus.START = 1'b0;
        check("b2b_second_done", 32'(bus.DONE), 32'h1);
        check("b2b_second_led",  32'(bus.LED),  32'h0003);
        check("b2b_second_flag", 32'(bus.FLAG), 32'h0);
        bus.SW = 16'hAAAA;
        tick();
        tick();
        check("idle_done",     32'(bus.DONE), 32'h0);
        check("idle_led_hold", 32'(bus.LED),  32'h0003);

        // Undefined selector encoding
        issue(opr_mode_t'(3'd7), 16'hFF01);
        check("undef_done", 32'(bus.DONE), 32'h1);
        check("undef_led",  32'(bus.LED),  32'h0);
        check("undef_flag", 32'(bus.FLAG), 32'h0);
        tick();

        // Reset in the middle of a MUL
        issue(OP_ADD, 16'hFF01);
        tick();
        issue(OP_MUL, 16'hFFFF);
        tick();
        tick();
        tick();
        check("mid_busy", 32'(bus.BUSY), 32'h1);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("async_led",  32'(bus.LED),  32'h0);
        check("async_flag", 32'(bus.FLAG), 32'h0);
        check("async_busy", 32'(bus.BUSY), 32'h0);
        check("async_done", 32'(bus.DONE), 32'h0);
        tick();
        #2;
        CPU_RESETN = 1'b1;
        tick();
        check("post_rst_done", 32'(bus.DONE), 32'h0);
        check("post_rst_busy", 32'(bus.BUSY), 32'h0);

        issue(OP_MUL, 16'h0203);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("mul2_busy", 32'(bus.BUSY), 32'h1);
        end
        tick();
        check("mul2_done", 32'(bus.DONE), 32'h1);
        check("mul2_led",  32'(bus.LED),  32'h0006);
        check("mul2_flag", 32'(bus.FLAG), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_select_action_seq
`default_nettype wire

// File: doc/select_action_seq.md
Name: select_action_seq

Overview:
- Registered, handshaked successor of the combinational mode selector.
- Parametrised in word width and adds a multi-cycle iterative multiplier, START/BUSY/DONE handshake, held result and a carry/borrow flag.
- Sits between board switches/buttons (debounced START) and the LED bank; one operation at a time.

Parameters:
- WIDTH, 16, SW/LED width; must be even and >= 4.
- HALF, WIDTH/2, operand width. Localparam, not overridable.

Ports:
- CLK100MHZ  input  1  system clock; all state on rising edge.
- CPU_RESETN  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle request; sampled only when BUSY=0.
- SELECTOR  input  opr_mode_t  operation; captured with START.
- SW  input  WIDTH  operand word; captured with START. A = SW[WIDTH-1:HALF], B = SW[HALF-1:0].
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; LED/FLAG valid and updated.
- LED  output  WIDTH  result register, held between operations.
- FLAG  output  1  ADD carry-out of HALF bits / SUB borrow (A<B); 0 for other ops.

Behaviour:
- Reset (CPU_RESETN=0, any time, including mid-MUL): state=IDLE, LED=0, FLAG=0, BUSY=0, DONE=0, multiplier cleared. First START is accepted on the first edge after release.
- FSM states:
  - IDLE: START=1 at edge E captures SELECTOR, A, B. MUL goes to MUL_RUN with BUSY=1. Every other op goes to DONE_ST, and LED/FLAG are written at edge E.
  - MUL_RUN: shift-add, one multiplier bit (LSB first) per cycle, for exactly HALF cycles. At edge E+HALF, LED = A*B (full WIDTH, no overflow possible), FLAG=0, go to DONE_ST.
  - DONE_ST: DONE=1 and BUSY=0 for exactly one cycle; return to IDLE. A START in this cycle is accepted (back-to-back), treated exactly as from IDLE.
- Latency: non-MUL ops give DONE in the cycle after START. MUL gives DONE HALF cycles after the START edge.
- Arithmetic per op:
  - RESET: LED=0, FLAG=0.
  - ADD: LED = zero-extended A+B. FLAG = bit HALF of the sum.
  - SUB: LED = (A - B) mod 2^WIDTH, operands zero-extended. FLAG = (A<B).
  - LEADING_ONES: LED = count of consecutive 1s from SW[WIDTH-1] downward, over the full captured SW (0..WIDTH), zero-extended.
  - COUNT_ONES: LED = popcount of the full captured SW, zero-extended.
  - Undefined SELECTOR encoding: LED=0, FLAG=0, normal 1-cycle DONE.
- START while BUSY=1 is ignored: no capture, no queueing, no effect on the running op.
- SW/SELECTOR changes after capture have no effect on the running op.
- LED and FLAG change only at the DONE-producing edge or at reset.

Decomposition:
- types_pkg holds opr_mode_t (existing encodings unchanged), a new fsm state enum seq_state_t {IDLE, MUL_RUN, DONE_ST}, and the leading_ones_fn/count_ones_fn functions generalised to WIDTH via parameterised class-static or width argument.
- One sub-module: seq_multiplier (params HALF; ports clock, reset, load, a, b, busy, done, product). It owns the shift-add datapath and its HALF-cycle counter. Top FSM sequences it.

Test Plan (WIDTH=16):
- Reset then ADD, SW=16'hFF01, START pulse -> next cycle DONE=1, LED=16'h0100, FLAG=1, BUSY never 1.
- SUB, SW=16'h0305 -> next cycle LED=16'hFFFE, FLAG=1; then SUB 16'h0503 -> LED=16'h0002, FLAG=0.
- MUL, SW=16'hFFFF -> BUSY=1 for 8 cycles, then DONE with LED=16'hFE01, FLAG=0. Extra START pulses and SW/SELECTOR changes during BUSY are ignored, and exactly one DONE is produced.
- LEADING_ONES, SW=16'hF0FF -> LED=4; COUNT_ONES, same SW -> LED=12; all-ones SW -> LED=16 for both.
- Back-to-back: START held during DONE cycle with ADD 16'h0102 -> second DONE next cycle, LED=16'h0003; LED held stable while idle.
- Assert CPU_RESETN=0 at cycle 4 of a MUL -> outputs 0 immediately (async). After release, a new MUL 16'h0203 gives LED=16'h0006 after 8 cycles.
